// File: rtl/master_port_burst.sv
// rtl/master_port_burst.sv - bit-serial burst bus master port
// Request/grant, slave-select with ack, address phase, then serial write or split-capable read beats.
module master_port_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int SEL_W     = 4,
  parameter int BURST_W   = 4,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mode,
  input  logic               rd_bus,
  output logic               wr_bus,
  input  logic               ack,
  output logic               master_valid,
  input  logic               slave_ready,
  output logic               master_ready,
  input  logic               slave_valid,
  output logic               breq,
  input  logic               bgrant,
  input  logic               split,
  input  logic               m_start,
  input  logic               m_mode,
  input  logic [ADDR_W-1:0]  m_addr,
  input  logic [BURST_W-1:0] m_len,
  input  logic [DATA_W-1:0]  m_wr_data,
  output logic               m_wr_req,
  output logic [DATA_W-1:0]  m_rd_data,
  output logic               m_rd_valid,
  output logic               m_busy,
  output logic               m_done,
  output logic               m_err
);

  localparam int CNT_W = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int RT_W  = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_SEL, S_ADDR, S_WR_DATA, S_RD_DATA, S_SPLIT, S_BACKOFF, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic               mode_q, wr_first, err_q, rd_valid_q;
  logic [ADDR_W-1:0]  addr_q, addr_sh;
  logic [BURST_W-1:0] len_q, beat_q;
  logic [RT_W-1:0]    retry_q;
  logic [TO_W-1:0]    to_q;
  logic [CNT_W-1:0]   bit_q;
  logic [DATA_W-1:0]  dat_sh, rd_data_q, wr_src;
  logic               set_err, beat_end, last_beat;
  logic               sel_last, addr_last, data_last;

  assign sel_last   = (bit_q == CNT_W'(SEL_W - 1));
  assign addr_last  = (bit_q == CNT_W'(ADDR_W - 1));
  assign data_last  = (bit_q == CNT_W'(DATA_W - 1));
  assign last_beat  = (beat_q == len_q);
  // The first write bit comes straight from the core in the cycle it is sampled.
  assign wr_src     = wr_first ? m_wr_data : dat_sh;
  assign mode       = mode_q & (state != S_IDLE);
  assign m_busy     = (state != S_IDLE);
  assign m_rd_data  = rd_data_q;
  assign m_rd_valid = rd_valid_q;

  always_comb begin
    state_nx     = state;
    breq         = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    wr_bus       = 1'b0;
    m_wr_req     = 1'b0;
    m_done       = 1'b0;
    m_err        = 1'b0;
    set_err      = 1'b0;
    beat_end     = 1'b0;
    case (state)
      S_IDLE: if (m_start) state_nx = S_REQ;
      S_REQ: begin
        breq = 1'b1;
        if (bgrant) state_nx = S_SEL;
      end
      S_SEL: begin
        breq         = 1'b1;
        master_valid = 1'b1;
        wr_bus       = addr_sh[ADDR_W-1];
        if (!bgrant) state_nx = S_BACKOFF;
        else if (slave_ready && sel_last) begin
          if (ack) state_nx = S_ADDR;
          else begin
            state_nx = S_DONE;
            set_err  = 1'b1;
          end
        end else if (to_q == TO_W'(TIMEOUT - 1)) state_nx = S_BACKOFF;
      end
      S_ADDR: begin
        breq         = 1'b1;
        master_valid = 1'b1;
        wr_bus       = addr_sh[ADDR_W-1];
        if (!bgrant) state_nx = S_BACKOFF;
        else if (slave_ready && addr_last) state_nx = mode_q ? S_WR_DATA : S_RD_DATA;
      end
      S_WR_DATA: begin
        breq         = 1'b1;
        master_valid = 1'b1;
        m_wr_req     = wr_first;
        wr_bus       = wr_src[DATA_W-1];
        if (!bgrant) state_nx = S_BACKOFF;
        else if (slave_ready && data_last) beat_end = 1'b1;
      end
      S_RD_DATA: begin
        // A split in the same cycle as a valid bit wins; that bit is not taken.
        breq         = 1'b1;
        master_ready = !split;
        if (split) state_nx = S_SPLIT;
        else if (!bgrant) state_nx = S_BACKOFF;
        else if (slave_valid && data_last) beat_end = 1'b1;
      end
      S_SPLIT: begin
        breq = 1'b1;
        if (!split && bgrant) state_nx = S_RD_DATA;
      end
      S_BACKOFF: begin
        if (retry_q >= RT_W'(MAX_RETRY)) begin
          state_nx = S_DONE;
          set_err  = 1'b1;
        end else state_nx = S_REQ;
      end
      S_DONE: begin
        m_done   = 1'b1;
        m_err    = err_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (beat_end) state_nx = last_beat ? S_DONE : S_SEL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      addr_q     <= '0;
      addr_sh    <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      retry_q    <= '0;
      to_q       <= '0;
      bit_q      <= '0;
      dat_sh     <= '0;
      wr_first   <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_nx;
      rd_valid_q <= 1'b0;
      wr_first   <= 1'b0;
      if (set_err) err_q <= 1'b1;
      case (state)
        S_IDLE: if (m_start) begin
          mode_q  <= m_mode;
          addr_q  <= m_addr;
          len_q   <= m_len;
          beat_q  <= '0;
          retry_q <= '0;
          err_q   <= 1'b0;
        end
        S_REQ: begin
          to_q    <= '0;
          bit_q   <= '0;
          addr_sh <= addr_q;
        end
        S_SEL: begin
          to_q <= to_q + 1'b1;
          if (bgrant && slave_ready) begin
            bit_q   <= bit_q + 1'b1;
            addr_sh <= addr_sh << 1;
          end
        end
        S_ADDR: if (bgrant && slave_ready) begin
          addr_sh <= addr_sh << 1;
          if (addr_last) begin
            bit_q    <= '0;
            wr_first <= mode_q;
          end else bit_q <= bit_q + 1'b1;
        end
        S_WR_DATA: begin
          if (bgrant && slave_ready) begin
            bit_q  <= bit_q + 1'b1;
            dat_sh <= {wr_src[DATA_W-2:0], 1'b0};
          end else if (wr_first) dat_sh <= m_wr_data;
        end
        S_RD_DATA: if (!split && bgrant && slave_valid) begin
          bit_q  <= bit_q + 1'b1;
          dat_sh <= {dat_sh[DATA_W-2:0], rd_bus};
          if (data_last) begin
            rd_data_q  <= {dat_sh[DATA_W-2:0], rd_bus};
            rd_valid_q <= 1'b1;
          end
        end
        S_BACKOFF: retry_q <= retry_q + 1'b1;
        default: ;
      endcase
      // Next beat keeps the bus and goes straight back to slave select.
      if (beat_end && !last_beat) begin
        beat_q  <= beat_q + 1'b1;
        addr_q  <= addr_q + 1'b1;
        addr_sh <= addr_q + 1'b1;
        to_q    <= '0;
        bit_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_master_port_burst.sv
// tb/tb_master_port_burst.sv - directed vector bench for master_port_burst
module tb_master_port_burst;

  logic        clk = 1'b0;
  logic        rst, mode, rd_bus, wr_bus, ack, master_valid, slave_ready;
  logic        master_ready, slave_valid, breq, bgrant, split;
  logic        m_start, m_mode, m_wr_req, m_rd_valid, m_busy, m_done, m_err;
  logic [15:0] m_addr;
  logic [3:0]  m_len;
  logic [7:0]  m_wr_data, m_rd_data;

  master_port_burst dut (
    .clk(clk), .rst(rst), .mode(mode), .rd_bus(rd_bus), .wr_bus(wr_bus), .ack(ack),
    .master_valid(master_valid), .slave_ready(slave_ready), .master_ready(master_ready),
    .slave_valid(slave_valid), .breq(breq), .bgrant(bgrant), .split(split),
    .m_start(m_start), .m_mode(m_mode), .m_addr(m_addr), .m_len(m_len),
    .m_wr_data(m_wr_data), .m_wr_req(m_wr_req), .m_rd_data(m_rd_data),
    .m_rd_valid(m_rd_valid), .m_busy(m_busy), .m_done(m_done), .m_err(m_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, n_hs_wr = 0, n_hs_rd = 0, n_wr_req = 0, n_rv = 0, n_done = 0;
  int          n_backoff = 0, n_split_bad = 0, sel_run = 0, last_run = 0;
  int          last_hs_cyc = 0, done_cyc = 0, rd_ptr = 0, rd_bit = 0;
  logic        last_err = 1'b0, breq_at_done = 1'b0, last_mode = 1'b0, hs_rd;
  logic [63:0] wr_bits = '0;
  logic [7:0]  rd_src[$];
  logic [7:0]  rd_log[$];
  logic [7:0]  cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bus monitor and serial read slave; samples 1ns before each rising edge.
  initial begin
    rd_bus = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (master_valid && slave_ready) begin
        n_hs_wr++;
        wr_bits = {wr_bits[62:0], wr_bus};
        last_hs_cyc = cyc;
      end
      hs_rd = master_ready && slave_valid;
      if (hs_rd) n_hs_rd++;
      if (m_wr_req) n_wr_req++;
      if (m_rd_valid) begin
        n_rv++;
        rd_log.push_back(m_rd_data);
      end
      if (m_busy && !breq && !m_done) n_backoff++;
      if (m_busy) last_mode = mode;
      if (m_done) begin
        n_done++;
        last_err = m_err;
        done_cyc = cyc;
        breq_at_done = breq;
      end
      if (split && (master_ready || (m_busy && !breq))) n_split_bad++;
      if (master_valid && !slave_ready) sel_run++;
      else begin
        if (!master_valid && sel_run != 0) last_run = sel_run;
        sel_run = 0;
      end
      if (hs_rd) begin
        rd_bit++;
        if (rd_bit == 8) begin
          rd_bit = 0;
          rd_ptr++;
        end
      end
      @(posedge clk);
      #1;
      if (rd_ptr < rd_src.size()) begin
        cur = rd_src[rd_ptr];
        rd_bus = cur[3'(7 - rd_bit)];
      end else rd_bus = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_xfer(input logic md, input logic [15:0] ad, input logic [3:0] ln,
                            input logic [7:0] wd);
    m_mode = md; m_addr = ad; m_len = ln; m_wr_data = wd; m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit, input int base);
    int k = 0;
    while (n_done == base && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done_seen"}, 64'(n_done - base), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic        mode;
    logic [15:0] addr;
    logic [3:0]  len;
    logic [7:0]  wdata;
    logic [23:0] rd;
    int          exp_hs;
    logic [23:0] exp_tail;
  } vec_t;

  vec_t vecs[4];
  vec_t v;
  int   b_done, b_hs, b_hsr, b_req, b_rv, b_bo, b_log, k;
  logic [7:0] got;

  initial begin
    vecs[0] = '{1'b1, 16'hA5C3, 4'd0, 8'h3C, 24'h000000, 24, 24'hA5C33C};
    vecs[1] = '{1'b1, 16'hFFFF, 4'd1, 8'h81, 24'h000000, 48, 24'h000081};
    vecs[2] = '{1'b0, 16'h1FFE, 4'd2, 8'h00, 24'h112233, 48, 24'h002000};
    vecs[3] = '{1'b0, 16'h7F0F, 4'd0, 8'h00, 24'hC60000, 16, 24'h007F0F};

    rst = 1'b1; bgrant = 1'b1; ack = 1'b1; slave_ready = 1'b1; slave_valid = 1'b1;
    split = 1'b0; m_start = 1'b0; m_mode = 1'b0; m_addr = '0; m_len = '0; m_wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_breq", 64'(breq), 64'd0);
    chk("rst_mvalid", 64'(master_valid), 64'd0);
    chk("rst_mready", 64'(master_ready), 64'd0);
    chk("rst_busy", 64'(m_busy), 64'd0);
    chk("rst_mode", 64'(mode), 64'd0);
    chk("rst_wr_bus", 64'(wr_bus), 64'd0);
    chk("rst_rd_data", 64'(m_rd_data), 64'd0);
    chk("rst_done", 64'({m_done, m_err, m_rd_valid, m_wr_req}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      b_done = n_done; b_hs = n_hs_wr; b_req = n_wr_req; b_rv = n_rv;
      b_bo = n_backoff; b_log = rd_log.size();
      if (!v.mode)
        for (int j = 0; j <= int'(v.len); j++) rd_src.push_back(v.rd[23 - 8*j -: 8]);
      start_xfer(v.mode, v.addr, v.len, v.wdata);
      wait_done($sformatf("v%0d", i), 400, b_done);
      chk($sformatf("v%0d_err", i), 64'(last_err), 64'd0);
      chk($sformatf("v%0d_mode", i), 64'(last_mode), 64'(v.mode));
      chk($sformatf("v%0d_hs", i), 64'(n_hs_wr - b_hs), 64'(v.exp_hs));
      chk($sformatf("v%0d_no_backoff", i), 64'(n_backoff - b_bo), 64'd0);
      chk($sformatf("v%0d_tail", i), v.mode ? 64'(wr_bits[23:0]) : 64'(wr_bits[15:0]),
          64'(v.exp_tail));
      if (v.mode) chk($sformatf("v%0d_wr_req", i), 64'(n_wr_req - b_req), 64'(int'(v.len) + 1));
      else begin
        chk($sformatf("v%0d_rd_valid", i), 64'(n_rv - b_rv), 64'(int'(v.len) + 1));
        for (int j = 0; j <= int'(v.len); j++) begin
          got = (b_log + j < rd_log.size()) ? rd_log[b_log + j] : 8'hxx;
          chk($sformatf("v%0d_rd_beat%0d", i, j), 64'(got), 64'(v.rd[23 - 8*j -: 8]));
        end
      end
      chk($sformatf("v%0d_idle", i), 64'(m_busy), 64'd0);
    end

    // NACK on the last select bit: DONE next cycle, error, no address phase
    ack = 1'b0;
    b_done = n_done; b_hs = n_hs_wr;
    start_xfer(1'b1, 16'h5000, 4'd0, 8'hFF);
    wait_done("nack", 100, b_done);
    chk("nack_err", 64'(last_err), 64'd1);
    chk("nack_hs", 64'(n_hs_wr - b_hs), 64'd4);
    chk("nack_latency", 64'(done_cyc - last_hs_cyc), 64'd1);
    chk("nack_breq", 64'(breq_at_done), 64'd0);
    ack = 1'b1;

    // Select-phase timeout, one back-off, then a clean transfer
    slave_ready = 1'b0;
    b_done = n_done; b_hs = n_hs_wr; b_bo = n_backoff;
    start_xfer(1'b1, 16'hA5C3, 4'd0, 8'h3C);
    k = 0;
    while (n_backoff == b_bo && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("to_backoff_seen", 64'(n_backoff - b_bo), 64'd1);
    chk("to_sel_cycles", 64'(last_run), 64'd64);
    slave_ready = 1'b1;
    wait_done("to", 300, b_done);
    chk("to_err", 64'(last_err), 64'd0);
    chk("to_backoffs", 64'(n_backoff - b_bo), 64'd1);
    chk("to_hs", 64'(n_hs_wr - b_hs), 64'd24);
    chk("to_tail", 64'(wr_bits[23:0]), 64'hA5C33C);

    // Permanent stall: four back-offs then error
    slave_ready = 1'b0;
    b_done = n_done; b_bo = n_backoff;
    start_xfer(1'b1, 16'h1234, 4'd0, 8'h55);
    wait_done("exh", 1000, b_done);
    chk("exh_backoffs", 64'(n_backoff - b_bo), 64'd4);
    chk("exh_err", 64'(last_err), 64'd1);
    slave_ready = 1'b1;

    // Split after three read bits; grant dropped meanwhile; stray start ignored
    rd_src.push_back(8'hA7);
    b_done = n_done; b_hsr = n_hs_rd; b_rv = n_rv; b_log = rd_log.size();
    start_xfer(1'b0, 16'h0100, 4'd0, 8'h00);
    k = 0;
    while (n_hs_rd < b_hsr + 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("split_pre_bits", 64'(n_hs_rd - b_hsr), 64'd3);
    split = 1'b1; bgrant = 1'b0;
    m_mode = 1'b1; m_addr = 16'hFFFF; m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0; m_mode = 1'b0;
    repeat (9) @(negedge clk);
    chk("split_frozen_bits", 64'(n_hs_rd - b_hsr), 64'd3);
    split = 1'b0; bgrant = 1'b1;
    wait_done("split", 200, b_done);
    chk("split_bad_cycles", 64'(n_split_bad), 64'd0);
    chk("split_bits", 64'(n_hs_rd - b_hsr), 64'd8);
    chk("split_rd_valid", 64'(n_rv - b_rv), 64'd1);
    got = (b_log < rd_log.size()) ? rd_log[b_log] : 8'hxx;
    chk("split_data", 64'(got), 64'hA7);
    chk("split_hold", 64'(m_rd_data), 64'hA7);
    chk("split_err", 64'(last_err), 64'd0);

    // Reset mid-transfer aborts with no completion pulse
    b_done = n_done;
    start_xfer(1'b1, 16'hA5C3, 4'd0, 8'h3C);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(m_busy), 64'd0);
    chk("abort_breq", 64'(breq), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(n_done - b_done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
